// File: rtl/o_result_collector.sv
// Drain stage for the PE group: tags each result word with lane/round, buffers it in a
// first-word-fall-through FIFO and replays it to writeback with an end-of-tile marker.
module o_result_collector #(
  parameter int DataWidth       = 32,
  parameter int BufferWidth     = 4,
  parameter int BufferSize      = 16,
  parameter int O_PEGroupSize   = 4,
  parameter int O_PEAddrWidth   = 2,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 2
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       Start,
  input  logic                       DataInValid,
  output logic                       DataInRdy,
  input  logic [DataWidth-1:0]       DataIn,
  output logic                       DataOutValid,
  input  logic                       DataOutRdy,
  output logic [DataWidth-1:0]       DataOut,
  output logic [O_PEAddrWidth-1:0]   DataOutLane,
  output logic [BlockCountWidth-1:0] DataOutBlock,
  output logic                       DataOutLast,
  output logic                       Busy,
  output logic                       Done,
  output logic [1:0]                 state_dbg
);

  localparam int EntryWidth = 1 + BlockCountWidth + O_PEAddrWidth + DataWidth;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Handshake rule for both ports: a word moves on a rising edge where valid and rdy
  // are both high; valid is never derived from the opposite side's rdy.

  state_t state, state_next;

  logic [BufferWidth-1:0]     wr_ptr, rd_ptr;
  logic [BufferWidth:0]       count;
  logic [O_PEAddrWidth-1:0]   lane;
  logic [BlockCountWidth-1:0] round;
  logic [EntryWidth-1:0]      mem [BufferSize];
  logic [EntryWidth-1:0]      head;

  logic push, pop, in_last, collect_en, lane_wrap;

  assign lane_wrap = (lane == O_PEAddrWidth'(O_PEGroupSize - 1));
  assign in_last   = lane_wrap && (round == BlockCountWidth'(BlockCount - 1));

  // A full FIFO refuses input even if a pop frees a slot in the same cycle.
  assign DataInRdy    = collect_en && (count < (BufferWidth + 1)'(BufferSize));
  assign DataOutValid = (count != '0);
  assign push         = DataInValid && DataInRdy;
  assign pop          = DataOutValid && DataOutRdy;
  assign state_dbg    = state;

  // Head entry is masked when empty so every output reads 0 after reset.
  assign head = mem[rd_ptr];
  assign {DataOutLast, DataOutBlock, DataOutLane, DataOut} = DataOutValid ? head : '0;

  // State register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = COLLECT;
      COLLECT: if (push && in_last) state_next = DRAIN;
      DRAIN:   if (pop && DataOutLast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    collect_en = 1'b0;
    Busy       = 1'b0;
    case (state)
      IDLE:    begin collect_en = 1'b0; Busy = 1'b0; end
      COLLECT: begin collect_en = 1'b1; Busy = 1'b1; end
      DRAIN:   begin collect_en = 1'b0; Busy = 1'b1; end
      default: begin collect_en = 1'b0; Busy = 1'b0; end
    endcase
  end

  // Done fires the cycle after the tile's final word leaves.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      Done <= 1'b0;
    end else begin
      Done <= (state == DRAIN) && pop && DataOutLast;
    end
  end

  // Lane/round tagging: cleared when a tile is armed, advanced per accepted word.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      lane  <= '0;
      round <= '0;
    end else if ((state == IDLE) && Start) begin
      lane  <= '0;
      round <= '0;
    end else if (push) begin
      if (lane_wrap) begin
        lane  <= '0;
        round <= round + BlockCountWidth'(1);
      end else begin
        lane  <= lane + O_PEAddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_last, round, lane, DataIn};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BufferWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + BufferWidth'(1);
      case ({push, pop})
        2'b10:   count <= count + (BufferWidth + 1)'(1);
        2'b01:   count <= count - (BufferWidth + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
